mem_port_arbiter: RTL and testbench

Shares the single-ported unified 19-bit memory between the IF stage (instruction fetch) and the MEM stage (load/store driven by the EX/MEM pipeline register outputs). Runs a request/acknowledge FSM toward the memory, gives data accesses priority, returns read data with one-cycle done pulses, and drives the stall signals that freeze the pipeline while an access is outstanding. A watchdog aborts accesses that are never acknowledged.

---
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-ported 19-bit memory between instruction fetch and MEM-stage loads/stores.
// Latency: the request registers one cycle after it is seen in IDLE; done/valid pulses one cycle after mem_ack (minimum 2 cycles).
// Backpressure: stall_pipe/stall_if freeze the pipeline while an access is pending; a watchdog aborts unacknowledged requests.
module mem_port_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MEM_memread,
  input  logic        MEM_memwrite,
  input  logic [18:0] MEM_out,
  input  logic [18:0] MEM_wdata,
  input  logic        if_req,
  input  logic [18:0] if_addr,
  input  logic        mem_ack,
  input  logic [18:0] mem_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [18:0] mem_addr,
  output logic [18:0] mem_wdata,
  output logic [18:0] data_rdata,
  output logic        data_done,
  output logic [18:0] if_rdata,
  output logic        if_valid,
  output logic        stall_pipe,
  output logic        stall_if,
  output logic        bus_err
);

  // Counter only has to reach TIMEOUT-1, so it can never wrap.
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FETCH = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          data_pend;
  logic          fetch_pend;
  logic          timeout_hit;

  // A request is no longer pending in the cycle its completion pulse is
  // shown, so the same instruction is never reissued before it advances.
  assign data_pend   = (MEM_memread | MEM_memwrite) & ~data_done;
  assign fetch_pend  = if_req & ~if_valid;
  assign timeout_hit = (cnt == CNT_LAST);

  // Stall outputs: data access freezes the whole front of the pipe, fetch only PC and IF/ID.
  assign stall_pipe = data_pend | (state == DATA);
  assign stall_if   = stall_pipe | fetch_pend | (state == FETCH);

  // Request/acknowledge FSM with registered memory-side outputs, result registers and watchdog.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      data_rdata <= '0;
      if_rdata   <= '0;
      data_done  <= 1'b0;
      if_valid   <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      // Completion pulses last exactly one cycle.
      data_done <= 1'b0;
      if_valid  <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          // Data access wins a tie: it belongs to the older instruction.
          if (data_pend) begin
            state     <= DATA;
            mem_req   <= 1'b1;
            mem_we    <= MEM_memwrite;
            mem_addr  <= MEM_out;
            mem_wdata <= MEM_wdata;
          end else if (fetch_pend) begin
            state    <= FETCH;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= if_addr;
          end else begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
        end
        DATA: begin
          // An ack on the watchdog's last cycle still counts as a normal completion.
          if (mem_ack) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            data_done <= 1'b1;
            if (!mem_we) begin
              data_rdata <= mem_rdata;
            end
          end else if (timeout_hit) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            data_done  <= 1'b1;
            data_rdata <= '0;
            bus_err    <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        FETCH: begin
          if (mem_ack) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            if_valid <= 1'b1;
            if_rdata <= mem_rdata;
          end else if (timeout_hit) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            if_valid <= 1'b1;
            if_rdata <= '0;
            bus_err  <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          cnt     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: directed scoreboard bench for mem_port_arbiter with a programmable-latency memory responder.
// Latency: expectations are queued at stimulus time and popped when mem_req rises or a done/valid pulse appears.
// Backpressure: the bench holds MEM/IF requests until their completion pulse, as a stalled pipeline would.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int TIMEOUT = 16;

  typedef struct packed {
    logic        we;
    logic [18:0] addr;
    logic [18:0] wdata;
  } req_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MEM_memread;
  logic        MEM_memwrite;
  logic [18:0] MEM_out;
  logic [18:0] MEM_wdata;
  logic        if_req;
  logic [18:0] if_addr;
  logic        mem_ack;
  logic [18:0] mem_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [18:0] mem_addr;
  logic [18:0] mem_wdata;
  logic [18:0] data_rdata;
  logic        data_done;
  logic [18:0] if_rdata;
  logic        if_valid;
  logic        stall_pipe;
  logic        stall_if;
  logic        bus_err;

  logic        resp_ack = 1'b0;
  logic        spur_ack = 1'b0;
  assign mem_ack = resp_ack | spur_ack;

  int checks = 0;
  int failures = 0;

  req_t        req_q[$];
  logic [18:0] data_q[$];
  logic [18:0] if_q[$];
  logic [18:0] resp_q[$];
  int          ack_lat = 0;
  int          req_cyc = 0;
  logic        prev_req = 1'b0;
  req_t        mon_e;

  mem_port_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .MEM_memread(MEM_memread), .MEM_memwrite(MEM_memwrite),
    .MEM_out(MEM_out), .MEM_wdata(MEM_wdata),
    .if_req(if_req), .if_addr(if_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .data_rdata(data_rdata), .data_done(data_done),
    .if_rdata(if_rdata), .if_valid(if_valid),
    .stall_pipe(stall_pipe), .stall_if(stall_if), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic req_t mk_req(input logic we, input logic [18:0] addr, input logic [18:0] wdata);
    req_t r;
    r.we = we;
    r.addr = addr;
    r.wdata = wdata;
    return r;
  endfunction

  // Memory model: acks on the ack_lat-th cycle of a request (never when ack_lat is 0).
  initial begin
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req && rst_n) begin
        req_cyc = req_cyc + 1;
        if (ack_lat != 0 && req_cyc == ack_lat) begin
          resp_ack = 1'b1;
          if (resp_q.size() != 0) mem_rdata = resp_q.pop_front();
          else mem_rdata = '0;
        end else begin
          resp_ack = 1'b0;
        end
      end else begin
        req_cyc = 0;
        resp_ack = 1'b0;
      end
    end
  end

  // Monitor: compares each new request and each completion pulse against the queued expectation.
  always @(negedge clk) begin
    if (mem_req && !prev_req) begin
      if (req_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL req_unexpected: got request addr 0x%0h, required none", mem_addr);
      end else begin
        mon_e = req_q.pop_front();
        check("req_we", {31'd0, mem_we}, {31'd0, mon_e.we});
        check("req_addr", {13'd0, mem_addr}, {13'd0, mon_e.addr});
        if (mon_e.we) check("req_wdata", {13'd0, mem_wdata}, {13'd0, mon_e.wdata});
      end
    end
    prev_req = mem_req;
    if (data_done) begin
      if (data_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL data_done_unexpected: got pulse rdata 0x%0h, required none", data_rdata);
      end else begin
        check("data_rdata", {13'd0, data_rdata}, {13'd0, data_q.pop_front()});
      end
    end
    if (if_valid) begin
      if (if_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL if_valid_unexpected: got pulse rdata 0x%0h, required none", if_rdata);
      end else begin
        check("if_rdata", {13'd0, if_rdata}, {13'd0, if_q.pop_front()});
      end
    end
  end

  // Hard stop in case the design wedges despite the per-wait budgets.
  initial begin
    #100000;
    $display("FAIL global_timeout: got no completion, required finish");
    $fatal(1, "simulation time limit");
  end

  // Directed stimulus.
  initial begin : stim
    int n;
    rst_n = 1'b0; MEM_memread = 1'b0; MEM_memwrite = 1'b0;
    MEM_out = '0; MEM_wdata = '0;
    if_req = 1'b1; if_addr = 19'h00010;

    // Reset held two edges with a fetch already requested.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", {13'd0, mem_addr}, 32'd0);
    check("rst_data_rdata", {13'd0, data_rdata}, 32'd0);
    check("rst_if_rdata", {13'd0, if_rdata}, 32'd0);
    check("rst_pulses", {30'd0, data_done, if_valid}, 32'd0);
    check("rst_bus_err", {31'd0, bus_err}, 32'd0);

    // Fetch acked on its first request cycle.
    ack_lat = 1;
    resp_q.push_back(19'h5A5A5);
    req_q.push_back(mk_req(1'b0, 19'h00010, 19'h0));
    if_q.push_back(19'h5A5A5);
    rst_n = 1'b1; #1;
    check("release_req_low", {31'd0, mem_req}, 32'd0);
    check("release_stall_if", {31'd0, stall_if}, 32'd1);
    @(negedge clk);
    check("fetch_req_high", {31'd0, mem_req}, 32'd1);
    @(negedge clk);
    check("fetch_req_one_cycle", {31'd0, mem_req}, 32'd0);
    check("fetch_valid_pulse", {31'd0, if_valid}, 32'd1);
    check("fetch_stall_if_low", {31'd0, stall_if}, 32'd0);
    if_req = 1'b0;

    // Load and fetch collide in IDLE: load first, then fetch at M+2.
    @(negedge clk);
    ack_lat = 3;
    resp_q.push_back(19'h12345); resp_q.push_back(19'h0ABCD);
    req_q.push_back(mk_req(1'b0, 19'h00100, 19'h0));
    req_q.push_back(mk_req(1'b0, 19'h00020, 19'h0));
    data_q.push_back(19'h12345);
    if_q.push_back(19'h0ABCD);
    MEM_memread = 1'b1; MEM_out = 19'h00100; if_req = 1'b1; if_addr = 19'h00020; #1;
    n = 0;
    while (stall_pipe && n < 20) begin n++; @(negedge clk); #1; end
    check("collision_stall_cycles", n, 32'd4);
    check("collision_data_done", {31'd0, data_done}, 32'd1);
    check("collision_stall_if", {31'd0, stall_if}, 32'd1);
    MEM_memread = 1'b0;
    @(negedge clk);
    check("fetch_after_load_req", {31'd0, mem_req}, 32'd1);
    n = 0;
    while (!if_valid && n < 20) begin n++; @(negedge clk); end
    check("fetch_after_load_valid", {31'd0, if_valid}, 32'd1);
    if_req = 1'b0;

    // Store arrives while a fetch is outstanding; it waits, then leaves data_rdata alone.
    @(negedge clk);
    ack_lat = 3;
    resp_q.push_back(19'h11111); resp_q.push_back(19'h3FFFF);
    req_q.push_back(mk_req(1'b0, 19'h00030, 19'h0));
    req_q.push_back(mk_req(1'b1, 19'h00200, 19'h7FFFF));
    if_q.push_back(19'h11111);
    data_q.push_back(19'h12345);
    if_req = 1'b1; if_addr = 19'h00030;
    @(negedge clk); #1;
    check("store_fetch_active", {31'd0, mem_req}, 32'd1);
    MEM_memwrite = 1'b1; MEM_out = 19'h00200; MEM_wdata = 19'h7FFFF; #1;
    check("store_stall_pipe", {31'd0, stall_pipe}, 32'd1);
    check("store_fetch_we", {31'd0, mem_we}, 32'd0);
    n = 0;
    while (!if_valid && n < 20) begin n++; @(negedge clk); end
    check("store_fetch_valid", {31'd0, if_valid}, 32'd1);
    if_req = 1'b0;
    n = 0;
    while (!data_done && n < 20) begin n++; @(negedge clk); end
    check("store_done", {31'd0, data_done}, 32'd1);
    MEM_memwrite = 1'b0;

    // Ack while idle must be ignored.
    @(negedge clk);
    spur_ack = 1'b1;
    @(negedge clk);
    spur_ack = 1'b0;
    check("idle_ack_ignored", {29'd0, mem_req, data_done, if_valid}, 32'd0);

    // Never-acked load: watchdog aborts after TIMEOUT request cycles.
    ack_lat = 0;
    req_q.push_back(mk_req(1'b0, 19'h00300, 19'h0));
    data_q.push_back(19'h0);
    MEM_memread = 1'b1; MEM_out = 19'h00300;
    @(negedge clk);
    n = 0;
    while (mem_req && n < 40) begin n++; @(negedge clk); end
    check("timeout_req_cycles", n, 32'd16);
    check("timeout_done", {31'd0, data_done}, 32'd1);
    check("timeout_bus_err", {31'd0, bus_err}, 32'd1);
    MEM_memread = 1'b0;
    @(negedge clk);
    check("bus_err_sticky", {31'd0, bus_err}, 32'd1);
    check("timeout_single_pulse", {31'd0, data_done}, 32'd0);

    // Ack on the last watchdog cycle completes normally.
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_clears_bus_err", {31'd0, bus_err}, 32'd0);
    rst_n = 1'b1;
    ack_lat = 16;
    resp_q.push_back(19'h0F0F0);
    req_q.push_back(mk_req(1'b0, 19'h00310, 19'h0));
    data_q.push_back(19'h0F0F0);
    MEM_memread = 1'b1; MEM_out = 19'h00310;
    @(negedge clk);
    n = 0;
    while (mem_req && n < 40) begin n++; @(negedge clk); end
    check("late_ack_req_cycles", n, 32'd16);
    check("late_ack_done", {31'd0, data_done}, 32'd1);
    check("late_ack_no_bus_err", {31'd0, bus_err}, 32'd0);
    MEM_memread = 1'b0;

    // Reset in the second cycle of a data wait drops the request with no pulse.
    @(negedge clk);
    ack_lat = 0;
    req_q.push_back(mk_req(1'b0, 19'h00400, 19'h0));
    MEM_memread = 1'b1; MEM_out = 19'h00400;
    @(negedge clk);
    check("midrst_req_high", {31'd0, mem_req}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_req_dropped", {31'd0, mem_req}, 32'd0);
    check("midrst_no_done", {31'd0, data_done}, 32'd0);
    rst_n = 1'b1; MEM_memread = 1'b0;
    @(negedge clk);
    check("midrst_idle", {30'd0, mem_req, data_done}, 32'd0);

    // Every queued expectation must have been consumed.
    @(negedge clk);
    check("req_q_drained", req_q.size(), 32'd0);
    check("data_q_drained", data_q.size(), 32'd0);
    check("if_q_drained", if_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
